// File: rtl/wb_commit_grf.sv
`default_nettype none
// ============================================================================
//  Module      : wb_commit_grf
//  Description : Write-back commit stage. It decodes the registered W-stage
//                bundle, commits the result to a 32x32 general register file,
//                and serves two D-stage read ports with a same-cycle W->D
//                bypass. It also exports the commit triple to the hazard unit
//                and counts retired (non-bubble) instructions.
//                Optional macro GRF_DISPLAY_EN: prints a simulation trace line
//                for each commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_grf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      W_PC,
    input  logic [31:0]      W_instr,
    input  logic [31:0]      W_memOut,
    input  logic [31:0]      W_aluResult,
    input  logic [31:0]      W_hluResult,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    output logic [31:0]      D_rd1,
    output logic [31:0]      D_rd2,
    output logic             W_we,
    output logic [4:0]       W_addr,
    output logic [31:0]      W_data,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [1:0] c_SRC_ALU = 2'd0;
    localparam logic [1:0] c_SRC_HLU = 2'd1;
    localparam logic [1:0] c_SRC_MEM = 2'd2;
    localparam logic [1:0] c_SRC_PC8 = 2'd3;

    localparam logic [1:0] c_DST_RD  = 2'd0;
    localparam logic [1:0] c_DST_RT  = 2'd1;
    localparam logic [1:0] c_DST_RA  = 2'd2;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_wclass;
    logic [1:0]  w_src;
    logic [1:0]  w_dsel;
    logic [4:0]  w_dest;
    logic [31:0] w_result;

    // Register storage; index 0 exists only to keep indexing simple and is never written.
    logic [31:0]      r_regs [32];
    logic [CNT_W-1:0] r_retire;

    assign w_op    = W_instr[31:26];
    assign w_funct = W_instr[5:0];

    // Classify the instruction into write class, destination select and result source.
    always_comb begin
        w_wclass = 1'b0;
        w_src    = c_SRC_ALU;
        w_dsel   = c_DST_RD;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03: begin
                        w_wclass = 1'b1;
                        w_src    = c_SRC_ALU;
                    end
                    6'h10, 6'h12: begin
                        w_wclass = 1'b1;
                        w_src    = c_SRC_HLU;
                    end
                    6'h09: begin
                        w_wclass = 1'b1;
                        w_src    = c_SRC_PC8;
                    end
                    default: w_wclass = 1'b0;
                endcase
            end
            6'h03: begin
                w_wclass = 1'b1;
                w_src    = c_SRC_PC8;
                w_dsel   = c_DST_RA;
            end
            6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h0A, 6'h0B: begin
                w_wclass = 1'b1;
                w_src    = c_SRC_ALU;
                w_dsel   = c_DST_RT;
            end
            6'h23, 6'h21, 6'h25, 6'h20, 6'h24: begin
                w_wclass = 1'b1;
                w_src    = c_SRC_MEM;
                w_dsel   = c_DST_RT;
            end
            default: w_wclass = 1'b0;
        endcase
    end

    // Resolve destination index and result value from the decoded selects.
    always_comb begin
        case (w_dsel)
            c_DST_RT: w_dest = W_instr[20:16];
            c_DST_RA: w_dest = 5'd31;
            default:  w_dest = W_instr[15:11];
        endcase
        case (w_src)
            c_SRC_HLU: w_result = W_hluResult;
            c_SRC_MEM: w_result = W_memOut;
            c_SRC_PC8: w_result = W_PC + 32'd8;
            default:   w_result = W_aluResult;
        endcase
    end

    // A write to $0 is architecturally a no-op, so it is not reported as a commit.
    assign W_we   = w_wclass && (w_dest != 5'd0);
    assign W_addr = W_we ? w_dest   : 5'd0;
    assign W_data = W_we ? w_result : 32'd0;

    // Read ports: $0 is hard zero, a matching commit is bypassed, and reset forces zero
    // so nothing leaks through the bypass while the file is being cleared.
    always_comb begin
        if (reset || D_rs == 5'd0) begin
            D_rd1 = 32'd0;
        end else if (W_we && D_rs == W_addr) begin
            D_rd1 = W_data;
        end else begin
            D_rd1 = r_regs[D_rs];
        end
        if (reset || D_rt == 5'd0) begin
            D_rd2 = 32'd0;
        end else if (W_we && D_rt == W_addr) begin
            D_rd2 = W_data;
        end else begin
            D_rd2 = r_regs[D_rt];
        end
    end

    // Commit the result into the register file; reset wipes every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (W_we) begin
            r_regs[W_addr] <= W_data;
        end
    end

    // Count every non-bubble instruction reaching W; natural wrap at the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire <= '0;
        end else if (W_instr != 32'd0) begin
            r_retire <= r_retire + 1'b1;
        end
    end

    assign retire_cnt = r_retire;

`ifdef GRF_DISPLAY_EN
    // Trace each commit in simulation.
    always @(posedge clk) begin
        if (W_we && !reset) begin
            $display("@%h: $%d <= %h", W_PC, W_addr, W_data);
        end
    end
`else
    // No commit trace in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_grf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_commit_grf
//  Description : Directed self-checking bench for wb_commit_grf. Expected
//                values are queued as stimulus is applied and compared, in
//                order, against the observed outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_commit_grf;

    logic        clk;
    logic        reset;
    logic [31:0] W_PC;
    logic [31:0] W_instr;
    logic [31:0] W_memOut;
    logic [31:0] W_aluResult;
    logic [31:0] W_hluResult;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [31:0] D_rd1;
    logic [31:0] D_rd2;
    logic        W_we;
    logic [4:0]  W_addr;
    logic [31:0] W_data;
    logic [31:0] retire_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    wb_commit_grf #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .W_PC        (W_PC),
        .W_instr     (W_instr),
        .W_memOut    (W_memOut),
        .W_aluResult (W_aluResult),
        .W_hluResult (W_hluResult),
        .D_rs        (D_rs),
        .D_rt        (D_rt),
        .D_rd1       (D_rd1),
        .D_rd2       (D_rd2),
        .W_we        (W_we),
        .W_addr      (W_addr),
        .W_data      (W_data),
        .retire_cnt  (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %h expected <none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Apply one W-stage bundle just after a falling edge, then let it settle.
    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [31:0] hlu, input logic [4:0] rs,
                         input logic [4:0] rt);
        @(negedge clk);
        W_PC        = pc;
        W_instr     = instr;
        W_memOut    = mem;
        W_aluResult = alu;
        W_hluResult = hlu;
        D_rs        = rs;
        D_rt        = rt;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        W_PC = 0; W_instr = 0; W_memOut = 0; W_aluResult = 0; W_hluResult = 0;
        D_rs = 0; D_rt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;

        // Every address reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            D_rs = 5'(i);
            D_rt = 5'(31 - i);
            #1;
            expect_val("reset_rd1", 32'd0);
            expect_val("reset_rd2", 32'd0);
            check(D_rd1);
            check(D_rd2);
        end
        expect_val("reset_retire", 32'd0);
        check(retire_cnt);

        // ori $1 bypassed in the same cycle.
        drive(32'h3000, 32'h34011234, 0, 32'h00001234, 0, 5'd1, 5'd0);
        expect_val("ori_we", 32'd1);       check({31'd0, W_we});
        expect_val("ori_addr", 32'd1);     check({27'd0, W_addr});
        expect_val("ori_bypass", 32'h1234); check(D_rd1);

        // Bubble: value now comes from storage.
        drive(32'h3004, 32'h0, 0, 32'hFFFF_FFFF, 0, 5'd1, 5'd0);
        expect_val("ori_stored", 32'h1234); check(D_rd1);
        expect_val("bubble_we", 32'd0);     check({31'd0, W_we});
        expect_val("retire_1", 32'd1);      check(retire_cnt);

        // jal writes PC+8 into $31.
        drive(32'h3010, 32'h0C000000, 0, 32'h1111, 0, 5'd0, 5'd0);
        expect_val("jal_addr", 32'd31);        check({27'd0, W_addr});
        expect_val("jal_data", 32'h00003018);  check(W_data);

        // mfhi $4; $31 now read from storage.
        drive(32'h3018, 32'h00002010, 0, 32'h2222, 32'hDEADBEEF, 5'd31, 5'd4);
        expect_val("mfhi_addr", 32'd4);        check({27'd0, W_addr});
        expect_val("mfhi_data", 32'hDEADBEEF); check(W_data);
        expect_val("ra_stored", 32'h3018);     check(D_rd1);
        expect_val("mfhi_bypass", 32'hDEADBEEF); check(D_rd2);

        drive(32'h301C, 32'h0, 0, 0, 0, 5'd4, 5'd31);
        expect_val("mfhi_stored", 32'hDEADBEEF); check(D_rd1);
        expect_val("retire_3", 32'd3);           check(retire_cnt);

        // ori $0: not a commit, $0 stays zero.
        drive(32'h3020, 32'h34000005, 0, 32'h5, 0, 5'd0, 5'd0);
        expect_val("ori0_we", 32'd0);   check({31'd0, W_we});
        expect_val("ori0_addr", 32'd0); check({27'd0, W_addr});
        expect_val("ori0_data", 32'd0); check(W_data);
        expect_val("ori0_rd1", 32'd0);  check(D_rd1);

        // sw: no commit but still retires.
        drive(32'h3024, 32'hAC010000, 0, 32'h77, 0, 5'd1, 5'd0);
        expect_val("sw_we", 32'd0);    check({31'd0, W_we});
        expect_val("retire_4", 32'd4); check(retire_cnt);

        // beq: no commit.
        drive(32'h3028, 32'h10220003, 0, 32'h1, 0, 5'd1, 5'd2);
        expect_val("beq_we", 32'd0);    check({31'd0, W_we});
        expect_val("beq_data", 32'd0);  check(W_data);

        // lw $2: both ports bypass simultaneously.
        drive(32'h302C, 32'h8C020000, 32'hFFFF8000, 32'h40, 0, 5'd2, 5'd2);
        expect_val("lw_rd1", 32'hFFFF8000); check(D_rd1);
        expect_val("lw_rd2", 32'hFFFF8000); check(D_rd2);
        expect_val("retire_6", 32'd6);      check(retire_cnt);

        // addu $5 = 0x55 (ALU source); $2 from storage.
        drive(32'h3030, 32'h00002821, 32'h9, 32'h55, 32'h8, 5'd5, 5'd2);
        expect_val("addu_data", 32'h55);       check(W_data);
        expect_val("lw_stored", 32'hFFFF8000); check(D_rd2);

        // jalr $7 writes PC+8.
        drive(32'h0100, 32'h00003809, 32'h9, 32'h55, 32'h8, 5'd7, 5'd5);
        expect_val("jalr_addr", 32'd7);      check({27'd0, W_addr});
        expect_val("jalr_data", 32'h108);    check(W_data);
        expect_val("addu_stored", 32'h55);   check(D_rd2);

        drive(32'h0104, 32'h0, 0, 0, 0, 5'd5, 5'd2);
        expect_val("retire_9", 32'd9);       check(retire_cnt);

        // Asynchronous reset between edges clears everything at once.
        #2;
        reset = 1'b1;
        #1;
        expect_val("areset_rd5", 32'd0);    check(D_rd1);
        expect_val("areset_rd2", 32'd0);    check(D_rd2);
        expect_val("areset_retire", 32'd0); check(retire_cnt);

        // A commit presented across an edge while reset is high is discarded,
        // and its bypass does not leak out during reset.
        drive(32'h0200, 32'h34031234, 0, 32'h1234, 0, 5'd3, 5'd0);
        expect_val("rst_bypass_blocked", 32'd0); check(D_rd1);
        @(negedge clk);
        reset = 1'b0;
        W_instr = 32'h0;
        #1;
        expect_val("rst_write_dropped", 32'd0);  check(D_rd1);
        expect_val("rst_retire_held", 32'd0);    check(retire_cnt);
        D_rs = 5'd5;
        #1;
        expect_val("rst_lost_r5", 32'd0);        check(D_rd1);

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_commit_grf.md
Name: wb_commit_grf

Overview:
- Write-back end of the W pipeline register in the P6 pipelined MIPS CPU.
- Consumes the registered W-stage bundle (PC, instruction, memory/ALU/HLU results).
- Decodes the destination register and result source, then commits to a 32x32 general register file.
- Serves two D-stage read ports with same-cycle W-to-D bypass, exports the commit triple for the hazard/forwarding unit, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- W_PC  input  32  PC of the instruction in W
- W_instr  input  32  instruction word in W (0 = bubble/nop)
- W_memOut  input  32  load data, already extended
- W_aluResult  input  32  ALU result
- W_hluResult  input  32  HI/LO read result
- D_rs  input  5  read port 1 address
- D_rt  input  5  read port 2 address
- D_rd1  output  32  read port 1 data
- D_rd2  output  32  read port 2 data
- W_we  output  1  commit enable this cycle (0 when destination is $0)
- W_addr  output  5  commit destination
- W_data  output  32  commit data
- retire_cnt  output  CNT_W  count of non-bubble instructions that reached W

Behaviour:
- Decode is combinational from W_instr. op = [31:26], funct = [5:0].
- op=0, funct in {0x20,0x21,0x22,0x23,0x24,0x25,0x2A,0x2B,0x00,0x02,0x03}: dest = rd [15:11], data = W_aluResult.
- op=0, funct in {0x10 mfhi, 0x12 mflo}: dest = rd, data = W_hluResult.
- op=0, funct = 0x09 jalr: dest = rd, data = W_PC + 8.
- op = 0x03 jal: dest = 31, data = W_PC + 8.
- op in {0x08,0x09,0x0C,0x0D,0x0F,0x0A,0x0B}: dest = rt [20:16], data = W_aluResult.
- op in {0x23 lw, 0x21 lh, 0x25 lhu, 0x20 lb, 0x24 lbu}: dest = rt, data = W_memOut.
- All other encodings (stores, branches, j, jr, mult/div, mthi/mtlo, bubble): no write.
- W_we = write-class AND dest != 0. W_addr/W_data = decoded dest/data when W_we = 1, otherwise 0/0.
- Register file commits on the rising clk edge when W_we = 1. $0 is never stored and always reads 0.
- Read ports are combinational:
  - D_rdN = 0 if addr = 0.
  - D_rdN = W_data if W_we = 1 and addr = W_addr (bypass, 0-cycle latency).
  - Otherwise D_rdN = stored value.
  - Both ports may bypass simultaneously.
- Retire counter increments at the rising edge when W_instr != 0 and wraps at 2^CNT_W - 1 to 0. Writes to $0 still count.
- Reset: asynchronous. Immediately clears all 31 registers and retire_cnt. D_rd1/D_rd2 read 0 while reset is high. W_we/W_addr/W_data follow the decode of the W inputs (the upstream W register clears to 0, so they are 0/0/0). A write pending at a rising edge while reset is high is discarded. Reset mid-stream loses all register contents.
- Latency: written value is visible on the read port in the same cycle (bypass) and from storage in every following cycle.

Optional Feature:
- Macro GRF_DISPLAY_EN.
- Defined: at each rising edge with W_we = 1 and reset low, the block issues the simulation print "@%h: $%d <= %h" with W_PC, W_addr, W_data. Synthesis ignores the print.
- Undefined: no print statements are compiled. Functional behaviour is identical.

Test Plan:
- Reset, then read all 32 addresses -> every read returns 0; retire_cnt = 0.
- W_instr = 0x34011234 (ori $1), W_aluResult = 0x00001234, D_rs = 1 -> same cycle D_rd1 = 0x1234 via bypass with W_we = 1 and W_addr = 1. After the edge with W_instr = 0, D_rd1 = 0x1234 from storage. retire_cnt = 1.
- W_instr = 0x0C000000 (jal), W_PC = 0x00003010 -> W_addr = 31 and W_data = 0x00003018. Then W_instr = 0x00002010 (mfhi $4) with W_hluResult = 0xDEADBEEF -> $4 = 0xDEADBEEF.
- W_instr = 0x34000005 (ori $0) -> W_we = 0 and D_rs = 0 reads 0. W_instr = 0xAC010000 (sw) -> no write, but retire_cnt increments.
- W_instr = 0x8C020000 (lw $2), W_memOut = 0xFFFF8000, D_rs = D_rt = 2 -> D_rd1 = D_rd2 = 0xFFFF8000 in the same cycle.
- Write $5 = 0x55, then assert reset asynchronously between clock edges -> D_rd reads of $5 drop to 0 immediately; retire_cnt = 0.
